aes_req_scheduler: RTL
======================

// Module: aes_req_scheduler
// PURPOSE
//  Round-robin scheduler sharing one fully pipelined AES-128 encryption core among NREQ requesters.
//  Issues at most one {plaintext,key} job per cycle into the core and carries a requester tag alongside
//  the core pipeline. Routes each ciphertext back to its owner; limits per-requester in-flight jobs.
//  Sits between client blocks and the aes_128 core instance.
// PARAMETERS
//  NREQ     4   number of requesters (2..8)
//  LATENCY  21  cycles from core_state/core_key sampled by core to matching core_out valid
//  MAX_OUT  4   max in-flight jobs per requester (1..2**CNT_W-1)
//  CNT_W    3   width of per-requester outstanding counters
// PORTS
//  clk         in   1          clock, all logic on posedge
//  rst         in   1          asynchronous reset, active-high
//  req_valid   in   NREQ       job request per requester
//  req_ready   out  NREQ       grant; handshake = req_valid[i] & req_ready[i]
//  req_state   in   NREQ*128   plaintexts, requester i at [128*i +: 128]
//  req_key     in   NREQ*128   keys, same packing
//  core_state  out  128        registered plaintext to core
//  core_key    out  128        registered key to core
//  core_out    in   128        ciphertext from core
//  resp_valid  out  NREQ       one-cycle pulse, ciphertext for requester i on resp_data
//  resp_data   out  128        registered ciphertext (valid only with a resp_valid bit set)
//  busy        out  1          1 while any job is in flight
// BEHAVIOUR
//  Reset: req_ready=0, core_state=0, core_key=0, resp_valid=0, resp_data=0, busy=0; rr_ptr=0;
//   tag pipe cleared; all outstanding counters=0. Core has no reset; its output ignored until tags valid.
//  Eligibility: elig[i] = req_valid[i] & (outst[i] < MAX_OUT).
//  Arbitration (comb): first eligible index searching rr_ptr, rr_ptr+1, ... mod NREQ; one-hot req_ready;
//   req_ready may depend on req_valid. No eligible -> req_ready=0.
//  Issue: on handshake with i, next cycle core_state/core_key = req_state/req_key of i, tag = {1,i}
//   enters stage 0 of the tag pipe. rr_ptr <= (i+1) mod NREQ. No handshake -> core_state/key hold,
//   tag stage 0 = invalid. rr_ptr changes only on handshake.
//  Tag pipe: LATENCY stages, shifts every cycle, never stalls (core has no backpressure).
//  Response: when tag pipe output valid with index j: resp_valid <= onehot(j), resp_data <= core_out.
//   Handshake to resp_valid = LATENCY+1 cycles. Responses in issue order; consumer must accept
//   every pulse (no resp backpressure).
//  Counters: outst[i] +1 on issue to i, -1 on response to i; both in same cycle -> unchanged.
//   Never exceeds MAX_OUT, never below 0.
//  busy = any outst[i] != 0 (registered from counters).
//  Throughput: 1 job/cycle aggregate; single requester capped at MAX_OUT per LATENCY+1 cycles.
//  Reset mid-operation: all in-flight jobs dropped silently, no resp_valid for them after reset.
//  NREQ=1: requester always wins when eligible.
// CONFIGURATION
//  AES_SCHED_PRIO_EN defined: requester 0 has strict priority; granted whenever elig[0], rr order
//   applies among the others; rr_ptr does not advance on a requester-0 grant.
//  Not defined: pure round-robin across all NREQ as above.
// TESTING
//  1) Req0 only, key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff ->
//     resp_valid=0001 exactly LATENCY+1 cycles later, resp_data=69c4e0d86a7b0430d8cdb78070b4c55a.
//  2) All 4 valid continuously, prio macro off -> grant order 0,1,2,3,0...; responses same order,
//     one per cycle; each ciphertext matches a software AES model.
//  3) Req2 continuously valid, others idle, MAX_OUT=4 -> 4 grants in consecutive cycles, then
//     req_ready[2]=0 until first resp; steady state 4 issues per 22 cycles.
//  4) Issue and response for same requester in one cycle -> outst unchanged, busy stays 1.
//  5) Assert rst 10 cycles after 3 issues -> outputs zero, no resp_valid for 40 cycles, busy=0;
//     new job after release completes normally.
//  6) AES_SCHED_PRIO_EN, req0 and req1 always valid -> req0 granted until outst[0]=MAX_OUT,
//     then req1 granted; req0 regains grant after its first response.

Source files
------------

// File: rtl/aes_req_scheduler.sv
// Round-robin scheduler that shares one pipelined AES-128 core among NREQ requesters.
// Define AES_SCHED_PRIO_EN to give requester 0 strict priority over the round-robin group.
module aes_req_scheduler #(
    parameter int NREQ    = 4,
    parameter int LATENCY = 21,
    parameter int MAX_OUT = 4,
    parameter int CNT_W   = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid_i,
    output logic [NREQ-1:0]      req_ready_o,
    input  logic [NREQ*128-1:0]  req_state_i,
    input  logic [NREQ*128-1:0]  req_key_i,
    output logic [127:0]         core_state_o,
    output logic [127:0]         core_key_o,
    input  logic [127:0]         core_out_i,
    output logic [NREQ-1:0]      resp_valid_o,
    output logic [127:0]         resp_data_o,
    output logic                 busy_o
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [CNT_W-1:0]  outst_q [NREQ];
    logic [CNT_W-1:0]  outst_d [NREQ];
    logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [LATENCY-1:0] tag_vld_q;
    logic [IDX_W-1:0]  tag_idx_q [LATENCY];
    logic [127:0]      core_state_q, core_key_q;
    logic [NREQ-1:0]   resp_valid_q, resp_valid_d;
    logic [127:0]      resp_data_q;
    logic              busy_q, busy_d;

    logic [NREQ-1:0]   elig, elig_rr;
    logic              gnt_vld;
    logic [IDX_W-1:0]  gnt_idx;
    logic              hs;
    logic [127:0]      sel_state, sel_key;

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            elig[i] = req_valid_i[i] && (outst_q[i] < CNT_W'(MAX_OUT));
        end
        elig_rr = elig;
`ifdef AES_SCHED_PRIO_EN
        elig_rr[0] = 1'b0;
`endif
    end

    // Search rr_ptr, rr_ptr+1, ... wrapping at NREQ; first eligible wins.
    always_comb begin
        logic [IDX_W:0] cand;
        gnt_vld = 1'b0;
        gnt_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = {1'b0, rr_ptr_q} + (IDX_W+1)'(k);
            if (cand >= (IDX_W+1)'(NREQ)) begin
                cand = cand - (IDX_W+1)'(NREQ);
            end
            if (!gnt_vld && elig_rr[cand[IDX_W-1:0]]) begin
                gnt_vld = 1'b1;
                gnt_idx = cand[IDX_W-1:0];
            end
        end
`ifdef AES_SCHED_PRIO_EN
        if (elig[0]) begin
            gnt_vld = 1'b1;
            gnt_idx = '0;
        end
`endif
    end

    assign hs = gnt_vld;

    always_comb begin
        logic [IDX_W:0] nxt;
        req_ready_o = '0;
        sel_state   = '0;
        sel_key     = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_vld && gnt_idx == IDX_W'(i)) begin
                req_ready_o[i] = 1'b1;
                sel_state      = req_state_i[128*i +: 128];
                sel_key        = req_key_i[128*i +: 128];
            end
        end
        nxt = {1'b0, gnt_idx} + (IDX_W+1)'(1);
        if (nxt >= (IDX_W+1)'(NREQ)) begin
            nxt = '0;
        end
        rr_ptr_d = rr_ptr_q;
`ifdef AES_SCHED_PRIO_EN
        if (hs && gnt_idx != '0) begin
            rr_ptr_d = nxt[IDX_W-1:0];
        end
`else
        if (hs) begin
            rr_ptr_d = nxt[IDX_W-1:0];
        end
`endif
    end

    // Last tag stage lines up with the core output for the job it describes.
    always_comb begin
        resp_valid_d = '0;
        for (int i = 0; i < NREQ; i++) begin
            resp_valid_d[i] = tag_vld_q[LATENCY-1] && (tag_idx_q[LATENCY-1] == IDX_W'(i));
        end
    end

    always_comb begin
        busy_d = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            outst_d[i] = outst_q[i];
            if (req_ready_o[i] && !resp_valid_d[i]) begin
                outst_d[i] = outst_q[i] + CNT_W'(1);
            end else if (!req_ready_o[i] && resp_valid_d[i]) begin
                outst_d[i] = outst_q[i] - CNT_W'(1);
            end
            if (outst_d[i] != '0) begin
                busy_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q     <= '0;
            tag_vld_q    <= '0;
            core_state_q <= '0;
            core_key_q   <= '0;
            resp_valid_q <= '0;
            resp_data_q  <= '0;
            busy_q       <= 1'b0;
            for (int k = 0; k < LATENCY; k++) begin
                tag_idx_q[k] <= '0;
            end
            for (int i = 0; i < NREQ; i++) begin
                outst_q[i] <= '0;
            end
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            tag_vld_q    <= {tag_vld_q[LATENCY-2:0], hs};
            tag_idx_q[0] <= gnt_idx;
            for (int k = 1; k < LATENCY; k++) begin
                tag_idx_q[k] <= tag_idx_q[k-1];
            end
            if (hs) begin
                core_state_q <= sel_state;
                core_key_q   <= sel_key;
            end
            resp_valid_q <= resp_valid_d;
            if (tag_vld_q[LATENCY-1]) begin
                resp_data_q <= core_out_i;
            end
            busy_q <= busy_d;
            for (int i = 0; i < NREQ; i++) begin
                outst_q[i] <= outst_d[i];
            end
        end
    end

    assign core_state_o = core_state_q;
    assign core_key_o   = core_key_q;
    assign resp_valid_o = resp_valid_q;
    assign resp_data_o  = resp_data_q;
    assign busy_o       = busy_q;

endmodule
